// File: rtl/fetch_pc_ctrl.sv
// Instruction fetch PC controller: owns the PC, drives the imem req/ack
// handshake and hands fetched instructions to decode.
module fetch_pc_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             redirect_valid,
   input  logic [31:0]      npc_in,
   input  logic             stall,
   output logic             imem_req,
   output logic [31:0]      imem_addr,
   input  logic             imem_ack,
   input  logic [31:0]      imem_rdata,
   output logic             if_valid,
   input  logic             if_ready,
   output logic [31:0]      if_pc,
   output logic [31:0]      if_inst,
   output logic [31:0]      fetch_pc,
   output logic             misalign_err,
   output logic [CNT_W-1:0] redirect_cnt
);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      HOLD,
      KILL
   } state_e;

   state_e            state_q, state_d;
   logic [31:0]       pc_q, pc_d;
   logic [31:0]       kaddr_q, kaddr_d;
   logic              vld_q, vld_d;
   logic [31:0]       ipc_q, ipc_d;
   logic [31:0]       inst_q, inst_d;
   logic              mis_q, mis_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic [31:0]       target;
   logic              consume;

   assign target  = {npc_in[31:2], 2'b00};
   assign consume = if_ready && !stall;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      kaddr_d = kaddr_q;
      vld_d   = vld_q;
      ipc_d   = ipc_q;
      inst_d  = inst_q;
      mis_d   = mis_q;
      cnt_d   = cnt_q;

      if (redirect_valid) begin
         if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
         if (npc_in[1:0] != 2'b00) begin
            mis_d = 1'b1;
         end
      end

      unique case (state_q)
         IDLE: begin
            state_d = REQ;
            if (redirect_valid) begin
               pc_d = target;
            end
         end
         REQ: begin
            if (imem_ack && !redirect_valid) begin
               inst_d  = imem_rdata;
               ipc_d   = pc_q;
               vld_d   = 1'b1;
               pc_d    = pc_q + 32'd4;
               state_d = HOLD;
            end else if (imem_ack) begin
               pc_d    = target;
            end else if (redirect_valid) begin
               // the old request stays on the bus until its ack
               kaddr_d = pc_q;
               pc_d    = target;
               state_d = KILL;
            end
         end
         KILL: begin
            if (redirect_valid) begin
               pc_d = target;
            end
            if (imem_ack) begin
               state_d = REQ;
            end
         end
         HOLD: begin
            if (redirect_valid) begin
               vld_d   = 1'b0;
               pc_d    = target;
               state_d = REQ;
            end else if (consume) begin
               vld_d   = 1'b0;
               state_d = REQ;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
         kaddr_q <= RESET_PC;
         vld_q   <= 1'b0;
         ipc_q   <= 32'h0;
         inst_q  <= 32'h0;
         mis_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         kaddr_q <= kaddr_d;
         vld_q   <= vld_d;
         ipc_q   <= ipc_d;
         inst_q  <= inst_d;
         mis_q   <= mis_d;
         cnt_q   <= cnt_d;
      end
   end

   assign imem_req     = (state_q == REQ) || (state_q == KILL);
   assign imem_addr    = (state_q == KILL) ? kaddr_q : pc_q;
   assign if_valid     = vld_q;
   assign if_pc        = ipc_q;
   assign if_inst      = inst_q;
   assign fetch_pc     = pc_q;
   assign misalign_err = mis_q;
   assign redirect_cnt = cnt_q;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Bench for fetch_pc_ctrl: directed scenarios plus random traffic checked
// against a transaction-level model of the fetch pipeline.
module tb_fetch_pc_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        redirect_valid;
   logic [31:0] npc_in;
   logic        stall;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_pc;
   logic [31:0] if_inst;
   logic [31:0] fetch_pc;
   logic        misalign_err;
   logic [15:0] redirect_cnt;

   int errs = 0;
   int chks = 0;

   always #5 clk = ~clk;

   fetch_pc_ctrl #(.RESET_PC(32'h0), .CNT_W(16)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .redirect_valid(redirect_valid),
      .npc_in(npc_in),
      .stall(stall),
      .imem_req(imem_req),
      .imem_addr(imem_addr),
      .imem_ack(imem_ack),
      .imem_rdata(imem_rdata),
      .if_valid(if_valid),
      .if_ready(if_ready),
      .if_pc(if_pc),
      .if_inst(if_inst),
      .fetch_pc(fetch_pc),
      .misalign_err(misalign_err),
      .redirect_cnt(redirect_cnt)
   );

   // Model: a fetch is either in flight (possibly doomed by a redirect)
   // or an instruction is waiting for decode.
   bit          m_run;
   bit          m_busy;
   bit          m_doom;
   bit          m_have;
   logic [31:0] m_pc;
   logic [31:0] m_oaddr;
   logic [31:0] m_ipc;
   logic [31:0] m_inst;
   bit          m_mis;
   int          m_cnt;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      chks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic m_reset();
      m_run  = 0;
      m_busy = 0;
      m_doom = 0;
      m_have = 0;
      m_pc   = 32'h0;
      m_oaddr = 32'h0;
      m_ipc  = 32'h0;
      m_inst = 32'h0;
      m_mis  = 0;
      m_cnt  = 0;
   endtask

   task automatic m_step(input bit rd, input logic [31:0] t, input bit st,
                         input bit ak, input logic [31:0] dat, input bit rdy);
      logic [31:0] ta;
      ta = t & 32'hFFFF_FFFC;
      if (rd) begin
         if (m_cnt < 65535) m_cnt = m_cnt + 1;
         if (t[1:0] != 2'b00) m_mis = 1;
      end
      if (!m_run) begin
         m_run  = 1;
         m_busy = 1;
         if (rd) m_pc = ta;
      end else if (m_busy) begin
         if (ak) begin
            if (!m_doom && !rd) begin
               m_have = 1;
               m_ipc  = m_pc;
               m_inst = dat;
               m_pc   = m_pc + 4;
               m_busy = 0;
            end else begin
               m_doom = 0;
               if (rd) m_pc = ta;
            end
         end else if (rd) begin
            if (!m_doom) begin
               m_doom  = 1;
               m_oaddr = m_pc;
            end
            m_pc = ta;
         end
      end else if (rd) begin
         m_have = 0;
         m_pc   = ta;
         m_busy = 1;
      end else if (rdy && !st) begin
         m_have = 0;
         m_busy = 1;
      end
   endtask

   task automatic check_all();
      chk("req", 32'(imem_req), 32'(m_busy));
      chk("addr", imem_addr, (m_busy && m_doom) ? m_oaddr : m_pc);
      chk("if_valid", 32'(if_valid), 32'(m_have));
      chk("if_pc", if_pc, m_ipc);
      chk("if_inst", if_inst, m_inst);
      chk("fetch_pc", fetch_pc, m_pc);
      chk("misalign", 32'(misalign_err), 32'(m_mis));
      chk("cnt", 32'(redirect_cnt), 32'(m_cnt));
   endtask

   task automatic cyc(input bit rst, input bit rd, input logic [31:0] t,
                      input bit st, input bit ak, input logic [31:0] dat,
                      input bit rdy);
      rst_n          = !rst;
      redirect_valid = rd;
      npc_in         = t;
      stall          = st;
      imem_ack       = ak;
      imem_rdata     = dat;
      if_ready       = rdy;
      @(posedge clk);
      if (rst) m_reset();
      else     m_step(rd, t, st, ak, dat, rdy);
      #1;
      check_all();
   endtask

   task automatic rnd_cyc(input int rst_pct, input bit force_rd);
      bit          r;
      bit          rd;
      logic [31:0] t;
      r  = ($urandom_range(0, 999) < rst_pct);
      rd = force_rd || ($urandom_range(0, 4) == 0);
      t  = $urandom;
      if ($urandom_range(0, 7) != 0) t[1:0] = 2'b00;
      cyc(r, rd, t, $urandom_range(0, 3) == 0,
          m_busy && m_run && ($urandom_range(0, 2) == 0),
          $urandom, $urandom_range(0, 3) != 0);
   endtask

   initial begin
      m_reset();
      cyc(1, 0, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0);
      chk("rst_req", 32'(imem_req), 32'h0);
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_cnt", 32'(redirect_cnt), 32'h0);

      // sequential fetches with immediate ack and consume
      cyc(0, 0, 0, 0, 0, 0, 1);
      chk("seq_a0", imem_addr, 32'h0);
      cyc(0, 0, 0, 0, 1, 32'h11, 1);
      chk("seq_i0", if_inst, 32'h11);
      cyc(0, 0, 0, 0, 0, 0, 1);
      chk("seq_a1", imem_addr, 32'h4);
      cyc(0, 0, 0, 0, 1, 32'h22, 1);
      chk("seq_p1", if_pc, 32'h4);

      // stall holds the instruction despite if_ready
      repeat (3) cyc(0, 0, 0, 1, 0, 0, 1);
      chk("stl_v", 32'(if_valid), 32'h1);
      chk("stl_i", if_inst, 32'h22);
      cyc(0, 0, 0, 0, 0, 0, 1);
      chk("stl_a", imem_addr, 32'h8);

      // redirect while fetch outstanding: old addr held, data dropped
      cyc(0, 1, 32'h100, 0, 0, 0, 1);
      chk("kill_a", imem_addr, 32'h8);
      cyc(0, 0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 1, 32'hDEAD, 1);
      chk("kill_v", 32'(if_valid), 32'h0);
      chk("kill_n", imem_addr, 32'h100);
      chk("kill_c", 32'(redirect_cnt), 32'h1);

      // redirect coinciding with ack
      cyc(0, 1, 32'h200, 0, 1, 32'hBEEF, 1);
      chk("coin_a", imem_addr, 32'h200);
      chk("coin_v", 32'(if_valid), 32'h0);

      // redirect in HOLD squashes the instruction
      cyc(0, 0, 0, 0, 1, 32'h33, 0);
      cyc(0, 1, 32'h40, 0, 0, 0, 0);
      chk("hold_v", 32'(if_valid), 32'h0);
      chk("hold_a", imem_addr, 32'h40);

      // misaligned target is aligned and flagged
      cyc(0, 1, 32'h103, 0, 1, 0, 1);
      chk("mis_a", imem_addr, 32'h100);
      chk("mis_f", 32'(misalign_err), 32'h1);

      repeat (3000) rnd_cyc(0, 0);
      repeat (3000) rnd_cyc(8, 0);

      // saturate the redirect counter
      cyc(1, 0, 0, 0, 0, 0, 0);
      repeat (65540) rnd_cyc(0, 1);
      chk("sat", 32'(redirect_cnt), 32'hFFFF);
      repeat (3) rnd_cyc(0, 1);
      chk("sat_hold", 32'(redirect_cnt), 32'hFFFF);

      // reset mid-request
      cyc(0, 0, 0, 0, 0, 0, 1);
      chk("pre_rst_req", 32'(imem_req), 32'h1);
      cyc(1, 0, 0, 0, 0, 0, 0);
      chk("mrst_req", 32'(imem_req), 32'h0);
      chk("mrst_v", 32'(if_valid), 32'h0);
      chk("mrst_mis", 32'(misalign_err), 32'h0);
      chk("mrst_cnt", 32'(redirect_cnt), 32'h0);
      cyc(0, 0, 0, 0, 0, 0, 1);
      chk("mrst_first", imem_addr, 32'h0);
      chk("mrst_freq", 32'(imem_req), 32'h1);

      $display("Result: errors=%0d of %0d checks", errs, chks);
      $finish;
   end

endmodule
